// File: rtl/feeder_pkg.sv
// Shared types and constants for the instruction feeder.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } feeder_state_t;

  // Copy r0 -> r0: harmless filler byte for the CPU.
  localparam logic [7:0] NOP_DEFAULT = 8'h40;

  // Opcode class occupies the top two bits of an instruction byte.
  localparam logic [1:0] IMM  = 2'b00;
  localparam logic [1:0] COPY = 2'b01;
  localparam logic [1:0] ALU  = 2'b10;
  localparam logic [1:0] COND = 2'b11;

  // Assemble an instruction byte from its class and 6-bit operand field.
  function automatic logic [7:0] mkInstr(input logic [1:0] opClass, input logic [5:0] operand);
    return {opClass, operand};
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: one synchronous write port, one asynchronous read port, no reset.
module prog_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Byte write from the loader.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: loads a byte-stream program and serves bytes to the CPU.
// Optional build macro FEEDER_CHECKSUM_EN enables the running load checksum;
// without it the checksum port is tied to zero.
module instr_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [7:0]  NOP_INSTR = NOP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       run,
  input  logic [7:0] next_addr,
  output logic [7:0] instruction,
  output logic [8:0] prog_len,
  output logic       halted,
  output logic [7:0] checksum
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  feeder_state_t state, stateNext;
  logic [AW-1:0] wptr;
  logic [8:0]    progLen;
  logic          clearLoad, acceptByte, loadDone, inRange;
  logic [7:0]    ramData;

  // Lengths never exceed DEPTH, so this also rejects addresses >= DEPTH.
  assign inRange  = {1'b0, next_addr} < progLen;
  assign prog_len = progLen;

  prog_ram #(.DEPTH(DEPTH), .AW(AW)) uRam (
    .clk   (clk),
    .we    (acceptByte),
    .waddr (wptr),
    .wdata (load_data),
    .raddr (next_addr[AW-1:0]),
    .rdata (ramData)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state, load control and combinational CPU-facing outputs.
  always_comb begin
    stateNext   = state;
    clearLoad   = 1'b0;
    acceptByte  = 1'b0;
    loadDone    = 1'b0;
    instruction = NOP_INSTR;
    load_ready  = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          stateNext = LOAD;
          clearLoad = 1'b1;
        end else if (run && progLen != 9'd0) begin
          stateNext = RUN;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_start) begin
          clearLoad = 1'b1;
        end else if (load_valid) begin
          acceptByte = 1'b1;
          if (load_last || wptr == LAST_ADDR) begin
            loadDone  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      RUN: begin
        if (inRange) instruction = ramData;
        if (!run)          stateNext = IDLE;
        else if (!inRange) stateNext = HALT;
      end
      HALT: begin
        halted = 1'b1;
        if (load_start) begin
          stateNext = LOAD;
          clearLoad = 1'b1;
        end else if (!run) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Write pointer and program length bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      progLen <= '0;
    end else if (clearLoad) begin
      wptr    <= '0;
      progLen <= '0;
    end else if (acceptByte) begin
      wptr <= wptr + AW'(1);
      if (loadDone) progLen <= 9'(wptr) + 9'd1;
    end
  end

`ifdef FEEDER_CHECKSUM_EN
  logic [7:0] sumQ;

  // Mod-256 sum of bytes accepted in the current load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sumQ <= 8'h00;
    else if (clearLoad)  sumQ <= 8'h00;
    else if (acceptByte) sumQ <= sumQ + load_data;
  end

  assign checksum = sumQ;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: behavioural model plus directed literals.
module tb_instr_feeder;
  import feeder_pkg::*;

  localparam int DEPTH = 256;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start, load_valid, load_last, run;
  logic [7:0] load_data, next_addr;
  logic       load_ready, halted;
  logic [7:0] instruction, checksum;
  logic [8:0] prog_len;

  int nTests = 0;
  int nFail  = 0;

  instr_feeder #(.DEPTH(DEPTH), .NOP_INSTR(8'h40)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .run         (run),
    .next_addr   (next_addr),
    .instruction (instruction),
    .prog_len    (prog_len),
    .halted      (halted),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  int         mdlMode = M_IDLE;
  int         mdlLen  = 0;
  int         mdlWp   = 0;
  int         mdlSum  = 0;
  logic [7:0] mdlMem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModelLoad();
    mdlWp  = 0;
    mdlLen = 0;
    mdlSum = 0;
  endtask

  // Model update on each clock edge, reset acts immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdlMode = M_IDLE;
      clearModelLoad();
    end else begin
      case (mdlMode)
        M_IDLE: begin
          if (load_start) begin mdlMode = M_LOAD; clearModelLoad(); end
          else if (run && mdlLen != 0) mdlMode = M_RUN;
        end
        M_LOAD: begin
          if (load_start) clearModelLoad();
          else if (load_valid) begin
            mdlMem[mdlWp] = load_data;
            mdlSum = (mdlSum + int'(load_data)) % 256;
            mdlWp++;
            if (load_last || mdlWp == DEPTH) begin
              mdlLen  = mdlWp;
              mdlMode = M_IDLE;
            end
          end
        end
        M_RUN: begin
          if (!run) mdlMode = M_IDLE;
          else if (int'(next_addr) >= mdlLen) mdlMode = M_HALT;
        end
        default: begin
          if (load_start) begin mdlMode = M_LOAD; clearModelLoad(); end
          else if (!run) mdlMode = M_IDLE;
        end
      endcase
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] expInstr;
    logic [7:0] expSum;
    expInstr = (mdlMode == M_RUN && int'(next_addr) < mdlLen) ? mdlMem[next_addr] : 8'h40;
`ifdef FEEDER_CHECKSUM_EN
    expSum = 8'(mdlSum);
`else
    expSum = 8'h00;
`endif
    check("mdl_instruction", 32'(instruction), 32'(expInstr));
    check("mdl_load_ready", 32'(load_ready), 32'(mdlMode == M_LOAD));
    check("mdl_halted", 32'(halted), 32'(mdlMode == M_HALT));
    check("mdl_prog_len", 32'(prog_len), 32'(mdlLen));
    check("mdl_checksum", 32'(checksum), 32'(expSum));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    cyc(1);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    logic [7:0] expProg [4];
    expProg[0] = 8'h05; expProg[1] = 8'h48; expProg[2] = 8'h81; expProg[3] = 8'h40;

    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = 8'h00; run = 1'b0; next_addr = 8'h00;
    cyc(2);
    check("rst_instruction", 32'(instruction), 32'h40);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    rst_n = 1'b1;

    // run with nothing loaded stays idle
    run = 1'b1;
    cyc(3);
    check("empty_run_instr", 32'(instruction), 32'h40);
    check("empty_run_len", 32'(prog_len), 32'd0);
    check("empty_run_halted", 32'(halted), 32'd0);
    run = 1'b0;

    // three-byte program
    load_start = 1'b1; cyc(1); load_start = 1'b0;
    check("load_ready_on", 32'(load_ready), 32'd1);
    sendByte(mkInstr(IMM, 6'h05), 1'b0);
    sendByte(mkInstr(COPY, 6'h08), 1'b0);
    sendByte(mkInstr(ALU, 6'h01), 1'b1);
    check("load3_ready_drop", 32'(load_ready), 32'd0);
    check("load3_len", 32'(prog_len), 32'd3);
`ifdef FEEDER_CHECKSUM_EN
    check("load3_checksum", 32'(checksum), 32'hCE);
`endif

    // execute it and run off the end
    run = 1'b1; next_addr = 8'd0;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      next_addr = 8'(i);
      #1;
      check("run3_instr", 32'(instruction), 32'(expProg[i]));
      check("run3_not_halted", 32'(halted), 32'd0);
      cyc(1);
    end
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_nop", 32'(instruction), 32'h40);
    cyc(1);
    check("halt_held", 32'(halted), 32'd1);
    run = 1'b0;
    cyc(1);
    check("halt_exit", 32'(halted), 32'd0);

    // load_start beats run in IDLE
    load_start = 1'b1; run = 1'b1;
    cyc(1);
    load_start = 1'b0; run = 1'b0;
    check("prio_ready", 32'(load_ready), 32'd1);
    check("prio_len", 32'(prog_len), 32'd0);
    check("prio_instr", 32'(instruction), 32'h40);

    // restart mid-load: no byte taken on the restart cycle
    sendByte(8'h11, 1'b0);
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'h22;
    cyc(1);
    load_start = 1'b0; load_valid = 1'b0;

    // reset after two of five bytes
    sendByte(8'h10, 1'b0);
    sendByte(8'h20, 1'b0);
    load_valid = 1'b1; load_data = 8'h30;
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", 32'(load_ready), 32'd0);
    check("rstmid_len", 32'(prog_len), 32'd0);
    check("rstmid_checksum", 32'(checksum), 32'd0);
    load_valid = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // full-depth load without load_last
    load_start = 1'b1; cyc(1); load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) sendByte(8'(i * 7 + 3), 1'b0);
    check("full_ready", 32'(load_ready), 32'd0);
    check("full_len", 32'(prog_len), 32'd256);
`ifdef FEEDER_CHECKSUM_EN
    check("full_checksum", 32'(checksum), 32'h80);
`endif
    sendByte(8'hEE, 1'b0);
    check("extra_len", 32'(prog_len), 32'd256);
    check("extra_ready", 32'(load_ready), 32'd0);

    run = 1'b1; next_addr = 8'd0;
    cyc(1);
    check("full_addr0", 32'(instruction), 32'h03);
    next_addr = 8'd255; #1;
    check("full_addr255", 32'(instruction), 32'hFC);
    next_addr = 8'd128; #1;
    check("full_addr128", 32'(instruction), 32'h83);
    cyc(2);
    check("full_no_halt", 32'(halted), 32'd0);
    run = 1'b0;
    cyc(1);

    // reload from HALT while run is still high
    load_start = 1'b1; cyc(1); load_start = 1'b0;
    sendByte(mkInstr(COPY, 6'h2A), 1'b0);
    sendByte(mkInstr(COND, 6'h03), 1'b1);
    check("short_len", 32'(prog_len), 32'd2);
    run = 1'b1; next_addr = 8'd2;
    cyc(1);
    check("short_oob_nop", 32'(instruction), 32'h40);
    cyc(1);
    check("short_halted", 32'(halted), 32'd1);
    load_start = 1'b1;
    cyc(1);
    load_start = 1'b0; run = 1'b0;
    check("halt_reload_ready", 32'(load_ready), 32'd1);
    check("halt_reload_len", 32'(prog_len), 32'd0);
    sendByte(8'h99, 1'b1);
    check("reload_len", 32'(prog_len), 32'd1);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Program-side counterpart of the CPU: it is loaded with a byte-stream program and then serves the instruction byte for every `next_addr` the CPU presents.
- It holds the CPU on NOP whenever no valid program is running.
- It sits between the external loader/testbench and the CPU's `instruction`/`next_addr` pins.

Parameters:
- DEPTH, 256, program memory depth in bytes; power of two, 2..256.
- NOP_INSTR, 8'h40, byte driven when idle, loading, halted or out of range (copy r0 -> r0, no architectural effect).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  pulse: begin a new program load.
- load_valid  input  1  load byte valid.
- load_data  input  8  program byte.
- load_last  input  1  marks final byte of the program; qualified by load_valid.
- load_ready  output  1  feeder accepts a load byte this cycle.
- run  input  1  level: execute the loaded program.
- next_addr  input  8  CPU program counter.
- instruction  output  8  instruction byte to the CPU.
- prog_len  output  9  number of bytes in the loaded program, 0..DEPTH.
- halted  output  1  CPU ran past the end of the program.
- checksum  output  8  see Optional Feature.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, prog_len=0, write pointer=0, halted=0, load_ready=0, checksum=0.
  - instruction=NOP_INSTR.
  - Memory contents are not reset.
- States: IDLE, LOAD, RUN, HALT. state is registered; instruction, load_ready and halted decode combinationally from state (halted=1 only in HALT).
- IDLE:
  - load_start -> LOAD; write pointer, prog_len and checksum clear.
  - Otherwise run=1 and prog_len!=0 -> RUN.
  - load_start has priority over run.
  - run with prog_len=0 stays IDLE.
- LOAD:
  - load_ready=1.
  - A byte is accepted on a cycle where load_valid & load_ready: mem[wptr]<=load_data, wptr++.
  - Accepted byte with load_last=1 -> IDLE, prog_len<=wptr+1.
  - Accepted byte at wptr=DEPTH-1 -> IDLE, prog_len<=DEPTH, regardless of load_last (overflow truncation); load_ready is 0 from the next cycle.
  - load_start while in LOAD restarts the load (pointer, prog_len, checksum clear); no byte is accepted that cycle.
  - run is ignored in LOAD.
- RUN:
  - next_addr<prog_len: instruction=mem[next_addr], combinational async read, zero-cycle latency. The CPU samples it on the same edge.
  - next_addr>=prog_len: instruction=NOP_INSTR that cycle; state -> HALT at the next edge.
  - run=0 -> IDLE at the next edge; the current cycle still serves mem[next_addr].
  - load_start is ignored in RUN; the program is not modifiable while running.
- HALT:
  - instruction=NOP_INSTR.
  - load_start -> LOAD, with priority.
  - Otherwise run=0 -> IDLE.
  - run held high stays in HALT; a fresh run requires run low for at least 1 cycle.
- Width rules:
  - prog_len is 9 bits so DEPTH=256 is representable.
  - Address compare is next_addr zero-extended to 9 bits versus prog_len.
  - For DEPTH<256, addresses >=DEPTH are always out of range.
- Reset mid-load: the partial load is discarded (prog_len=0) and memory bytes are left stale.

Optional Feature:
- Macro: FEEDER_CHECKSUM_EN.
- Defined:
  - checksum is the mod-256 sum of all bytes accepted in the current load.
  - It clears on load_start and on reset, and is held stable outside LOAD.
- Undefined:
  - checksum is tied to 8'h00 and no adder is synthesised.
  - The port is still present, so the interface is identical either way.

Decomposition:
- Package feeder_pkg:
  - state enum feeder_state_t {IDLE, LOAD, RUN, HALT}.
  - NOP_INSTR default constant.
  - Opcode class constants: IMM=2'b00, COPY=2'b01, ALU=2'b10, COND=2'b11 (for bench instruction builders).
- Sub-module prog_ram: DEPTH x 8, one synchronous write port and one asynchronous read port, no reset. The feeder FSM instantiates it once.

Test Plan:
- Reset then run=1 with nothing loaded -> stays IDLE, instruction=8'h40, prog_len=0.
- load_start, stream 8'h05, 8'h48, 8'h81 with last on 8'h81 -> prog_len=3, load_ready drops in the cycle after the last byte, checksum=8'hCE (when enabled).
- run=1 with next_addr stepping 0,1,2,3 -> instruction 8'h05, 8'h48, 8'h81, 8'h40; halted=1 one cycle after addr 3; drop run -> IDLE.
- Load 256 bytes with load_last never asserted -> auto-return to IDLE, prog_len=256, load_ready=0; a 257th load_valid is not accepted.
- Assert rst_n low after 2 of 5 load bytes -> immediate IDLE, prog_len=0, load_ready=0, checksum=0.
- load_start and run asserted together in IDLE with prog_len=3 -> enters LOAD, prog_len=0, instruction stays 8'h40.
